// File: rtl/controle_diagonais.sv
// Flow controller for the buffer_diagonais/filter datapath. It scans one frame in raster
// order, tracks in-flight results with a valid shift register and applies ready/valid backpressure.
module controle_diagonais #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          in_valid_i,
  input  logic                          out_ready_i,
  output logic                          in_ready_o,
  output logic                          enable_o,
  output logic                          out_valid_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;

  logic stall, transfer, accept;

  assign out_valid_o = vld_q[PIPE_DEPTH-1];
  assign stall       = out_valid_o & ~out_ready_i;
  assign transfer    = out_valid_o & out_ready_i;

  // Handshake decode. The datapath only advances when a new window enters (RUN)
  // or when there is something left to flush and the output slot is free (DRAIN).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    in_ready_o = 1'b0;
    enable_o   = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        in_ready_o = ~stall;
        accept     = in_valid_i & ~stall;
        enable_o   = accept;
      end
      S_DRAIN: enable_o = ~stall & (|vld_q);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    col_d   = col_q;
    row_d   = row_q;

    if (enable_o) begin
      vld_d = {vld_q[PIPE_DEPTH-2:0], accept};
    end else if (transfer) begin
      // Frozen pipeline: only the consumed head result is retired.
      vld_d[PIPE_DEPTH-1] = 1'b0;
    end

    if (accept) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_HEIGHT - 1)) begin
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          vld_d   = '0;
        end
      end
      S_DRAIN: if (vld_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_i) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_controle_diagonais.sv
// Self-checking bench for controle_diagonais: a queue-of-ages frame model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_controle_diagonais;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PD = 3;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready_o, enable_o, out_valid_o, busy_o, done_o;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;

  controle_diagonais #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_DEPTH(PD)) dut (
    .clock_i    (clk),
    .reset_i    (reset),
    .start_i    (start),
    .in_valid_i (in_valid),
    .out_ready_i(out_ready),
    .in_ready_o (in_ready_o),
    .enable_o   (enable_o),
    .out_valid_o(out_valid_o),
    .col_o      (col_o),
    .row_o      (row_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Frame model: mode, pixels accepted in this frame, ages (enable count) of in-flight results.
  int m_mode = M_IDLE;
  int m_n    = 0;
  int m_age[$];
  bit m_known = 1'b0;

  // Per-test observations.
  int cyc = 0;
  int t_acc, t_xfer, t_done, t_first_acc, t_first_ov, t_last_acc, t_last_xfer, t_done_cyc;
  logic [2:0] t_rc[8];
  logic [7:0] s_vec;

  logic [2:0] exp_rc[8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {busy_o, done_o, in_ready_o, enable_o, out_valid_o, row_o, col_o};
  endfunction

  task automatic begin_test();
    t_acc = 0; t_xfer = 0; t_done = 0;
    t_first_acc = -1; t_first_ov = -1; t_last_acc = -1; t_last_xfer = -1; t_done_cyc = -1;
    for (int i = 0; i < 8; i++) t_rc[i] = '0;
  endtask

  // One clock cycle: compare against the model at the falling edge, then advance the model.
  task automatic step();
    bit ov, st, ir, acc, en;
    logic [RW-1:0] e_row;
    logic [CW-1:0] e_col;
    logic [7:0] e;
    @(negedge clk);
    ov    = (m_age.size() > 0) && (m_age[0] == PD - 1);
    st    = ov && !out_ready;
    ir    = (m_mode == M_RUN) && !st;
    acc   = ir && in_valid;
    en    = (m_mode == M_RUN) ? acc : ((m_mode == M_DRAIN) ? (!st && m_age.size() != 0) : 1'b0);
    e_row = RW'(m_n / W);
    e_col = CW'(m_n % W);
    e     = {m_mode != M_IDLE, m_mode == M_DONE, ir, en, ov, e_row, e_col};
    s_vec = dut_vec();
    if (m_known) check("cycle", {24'd0, s_vec}, {24'd0, e});

    if (in_ready_o && in_valid) begin
      if (t_acc < 8) t_rc[t_acc] = {row_o, col_o};
      if (t_first_acc < 0) t_first_acc = cyc;
      t_last_acc = cyc;
      t_acc++;
    end
    if (out_valid_o && t_first_ov < 0) t_first_ov = cyc;
    if (out_valid_o && out_ready) begin
      t_xfer++;
      t_last_xfer = cyc;
    end
    if (done_o) begin
      t_done++;
      t_done_cyc = cyc;
    end

    @(posedge clk);
    if (!reset) begin
      m_mode = M_IDLE; m_n = 0; m_age.delete(); m_known = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_RUN; m_n = 0; m_age.delete(); end
        M_RUN, M_DRAIN: begin
          if (en) begin
            if (ov) void'(m_age.pop_front());
            foreach (m_age[i]) m_age[i]++;
            if (acc) m_age.push_back(0);
          end else if (ov && out_ready) begin
            void'(m_age.pop_front());
          end
          if (m_mode == M_RUN) begin
            if (acc) begin
              m_n++;
              if (m_n == W * H) begin m_n = 0; m_mode = M_DRAIN; end
            end
          end else if (m_age.size() == 0) begin
            m_mode = M_DONE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
    cyc++;
    #1;
  endtask

  initial begin
    int left;
    bit held;

    // Reset held two cycles with start high: nothing leaves IDLE.
    reset = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    step();
    check("rst_snapshot", {24'd0, s_vec}, 32'd0);
    check("rst_outputs", {24'd0, dut_vec()}, 32'd0);
    reset = 1'b1; start = 1'b0;
    step();
    check("idle_after_rst", {24'd0, dut_vec()}, 32'd0);

    // Test 1: full-rate frame.
    begin_test();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 60 && t_done == 0; i++) step();
    check("t1_done_seen", t_done, 1);
    check("t1_accepts", t_acc, 8);
    check("t1_xfers", t_xfer, 8);
    check("t1_latency", 32'(t_first_ov - t_first_acc), 3);
    check("t1_burst", 32'(t_last_acc - t_first_acc), 7);
    check("t1_done_after_xfer", 32'(t_done_cyc - t_last_xfer), 1);
    for (int i = 0; i < 8; i++) check("t1_rowcol", {29'd0, t_rc[i]}, {29'd0, exp_rc[i]});
    check("t1_busy_low", {31'd0, busy_o}, 0);

    // Test 2: downstream stall for five cycles after the 4th accept.
    begin_test();
    start = 1'b1; step(); start = 1'b0;
    left = 5;
    for (int i = 0; i < 60 && t_done == 0; i++) begin
      held = (t_acc >= 4 && left > 0);
      out_ready = !held;
      if (held) left--;
      step();
      if (held) check("t2_stall", {24'd0, s_vec}, {24'd0, 8'b1000_1100});
    end
    out_ready = 1'b1;
    check("t2_done_seen", t_done, 1);
    check("t2_accepts", t_acc, 8);
    check("t2_xfers", t_xfer, 8);

    // Test 3: upstream gap of three cycles after the 2nd accept.
    begin_test();
    start = 1'b1; step(); start = 1'b0;
    left = 3;
    for (int i = 0; i < 60 && t_done == 0; i++) begin
      held = (t_acc >= 2 && left > 0);
      in_valid = !held;
      if (held) left--;
      step();
      if (held) check("t3_gap", {24'd0, s_vec}, {24'd0, 8'b1010_0010});
    end
    in_valid = 1'b1;
    check("t3_done_seen", t_done, 1);
    check("t3_xfers", t_xfer, 8);

    // Test 4: start held high for the whole frame, released once done is seen.
    begin_test();
    start = 1'b1;
    for (int i = 0; i < 60 && t_done == 0; i++) step();
    start = 1'b0;
    repeat (3) step();
    check("t4_single_done", t_done, 1);
    check("t4_accepts", t_acc, 8);
    for (int i = 0; i < 8; i++) check("t4_rowcol", {29'd0, t_rc[i]}, {29'd0, exp_rc[i]});
    check("t4_idle", {31'd0, busy_o}, 0);

    // Test 5: reset mid-frame at row 1, col 2 with results in flight.
    begin_test();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 40 && t_acc < 6; i++) step();
    check("t5_reached", t_acc, 6);
    reset = 1'b0;
    step();
    check("t5_pre_reset", {24'd0, s_vec}, {24'd0, 8'b1011_1110});
    check("t5_post_reset", {24'd0, dut_vec()}, 32'd0);
    reset = 1'b1;
    repeat (4) step();
    check("t5_no_done", t_done, 0);
    check("t5_idle", {24'd0, dut_vec()}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
